divider_complex: RTL and testbench
==================================

# divider_complex

Sequential fixed-point complex divider for the FFT datapath. Computes (di_real0 + j·di_img0) / (di_real1 + j·di_img1) in the same signed Q(WIDTH−Q_LENGTH).Q_LENGTH format used by the complex multiplier. It is the inverse operation to that multiplier and is used for equalisation and normalisation after the FFT stage. Each result is produced by an iterative restoring divider, one quotient bit per cycle, with a valid/ready handshake on both sides.

## Interface
- WIDTH, 32, total bits of every real/imag operand and result
- Q_LENGTH, 16, fractional bits
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- di_valid  in  1  operands valid
- di_ready  out  1  block can accept operands (high only in IDLE)
- di_real0, di_img0  in  WIDTH  signed numerator
- di_real1, di_img1  in  WIDTH  signed denominator
- do_valid  out  1  result valid; held until accepted
- do_ready  in  1  downstream accepts result
- do_real, do_img  out  WIDTH  signed quotient
- do_div_zero  out  1  denominator was 0+0j
- do_ovf  out  1  at least one component saturated

## Operation
- Math: num_r = r0·r1 + i0·i1; num_i = i0·r1 − r0·i1 (2·WIDTH+1 bits signed); den = r1² + i1² (2·WIDTH+1 bits, ≥ 0). Quotient = (num << Q_LENGTH) / den.
- Division is on magnitudes. Sign is applied afterwards. Rounding is truncation toward zero.
- Real and imag quotients are computed in parallel by two identical shift-subtract lanes sharing den.
- Overflow pre-check in PREP: |num|<<Q_LENGTH ≥ den<<WIDTH sets that lane's ovf.
- After DIV, a magnitude > 2^(WIDTH−1)−1 (positive) or > 2^(WIDTH−1) (negative) also sets ovf.
- An ovf lane saturates to 0x7FF…F or 0x800…0 according to its sign.
- den == 0: skip DIV, do_real = do_img = 0, do_div_zero = 1, do_ovf = 0.
- A zero numerator yields exactly 0, not −0 saturation.
- FSM states:
  - IDLE: di_ready = 1. di_valid & di_ready latches operands and moves to PREP.
  - PREP: register products, magnitudes, signs, pre-check and div-zero. Go to DONE if den == 0, else to DIV with bit counter = WIDTH−1.
  - DIV: one quotient bit per lane per cycle, counter decrements. After the bit-0 cycle, apply sign/saturation and go to DONE.
  - DONE: do_valid = 1 with outputs stable. do_valid & do_ready returns to IDLE.
- Operand inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, di_ready 1, do_valid 0, do_real/do_img 0, do_div_zero 0, do_ovf 0.
- Accept edge = cycle 0. PREP occupies cycle 1. DIV occupies cycles 2..WIDTH+1. do_valid is first high in cycle WIDTH+2 (34 at default).
- div_zero case: do_valid is high in cycle 2.
- With do_ready held high, do_valid lasts one cycle and di_ready rises the next cycle. Throughput is one result per WIDTH+3 cycles.
- do_ready low: the block stays in DONE indefinitely; outputs and flags must not change.
- There is no bypass: a new operand cannot be accepted in the same cycle a result is accepted.
- rst asserted in any state: the next cycle is in reset values, and the in-flight operation is discarded with no do_valid.
- rst has priority over simultaneous di_valid/do_ready.

## Structure
- The shared FFT package holds the WIDTH/Q_LENGTH defaults, the FSM state encoding (IDLE, PREP, DIV, DONE) and the saturation constants MAX_POS/MAX_NEG.
- One sub-module, div_lane_unsigned, is instantiated twice. It is the restoring shift-subtract step: remainder/quotient registers, load, step enable and shared divisor. The top holds the FSM, the products, sign handling and saturation.

## Test plan
- (1+1j)/(1+1j): inputs 0x00010000, 0x00010000, 0x00010000, 0x00010000 → do_real 0x00010000, do_img 0x00000000, flags 0, do_valid in cycle 34.
- (1+0j)/(0+1j) → do_real 0x00000000, do_img 0xFFFF0000.
- (3+4j)/(1+2j) → do_real 0x00023333, do_img 0xFFFF999A (truncation toward zero).
- Denominator 0+0j, numerator 5+5j → do_valid in cycle 2, do_div_zero 1, outputs 0. Then (7+0j)/(7+0j) → 0x00010000 with do_div_zero 0.
- (0x7FFF0000+0j)/(0x00000100+0j) → do_real 0x7FFFFFFF, do_ovf 1. Repeat with −0x7FFF0000 → 0x80000000.
- Backpressure and reset:
  - Hold do_ready low 10 cycles in DONE → outputs stable and di_ready 0 throughout.
  - Assert rst in cycle 15 of a divide → no do_valid, and di_ready is 1 the following cycle.

Source files
------------

// File: rtl/divider_complex_pkg.sv
// Shared definitions for the FFT complex divider: default widths, FSM encoding
// and saturation constants.
package divider_complex_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_Q_LENGTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Saturation limits at the default width.
  localparam logic [DEF_WIDTH-1:0] MAX_POS = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] MAX_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/divider_complex_div_lane_unsigned.sv
// Restoring shift-subtract divider lane: one quotient bit per step. Dividend bits
// shift out of the top of bits_reg while quotient bits shift into its bottom.
module div_lane_unsigned
  import divider_complex_pkg::*;
#(
  parameter int RW = 2*DEF_WIDTH+1,
  parameter int QW = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [RW-1:0] load_rem,
  input  logic [QW-1:0] load_bits,
  input  logic [RW-1:0] divisor,
  output logic [QW-1:0] quotient_next
);

  logic [RW-1:0] rem_reg;
  logic [RW-1:0] rem_next;
  logic [QW-1:0] bits_reg;
  logic [RW:0]   trial;
  logic          fits;

  // Remainder stays below the divisor, so the restored value fits in RW bits.
  always_comb begin
    trial         = {rem_reg, bits_reg[QW-1]};
    fits          = trial >= {1'b0, divisor};
    rem_next      = fits ? (trial[RW-1:0] - divisor) : trial[RW-1:0];
    quotient_next = {bits_reg[QW-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg  <= '0;
      bits_reg <= '0;
    end else if (load) begin
      rem_reg  <= load_rem;
      bits_reg <= load_bits;
    end else if (step) begin
      rem_reg  <= rem_next;
      bits_reg <= quotient_next;
    end
  end

endmodule

// File: rtl/divider_complex.sv
// Sequential fixed-point complex divider: (r0 + j i0) / (r1 + j i1) via two
// parallel restoring lanes over the conjugate-multiplied numerator.
module divider_complex
  import divider_complex_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int Q_LENGTH = DEF_Q_LENGTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di_valid,
  output logic             di_ready,
  input  logic [WIDTH-1:0] di_real0,
  input  logic [WIDTH-1:0] di_img0,
  input  logic [WIDTH-1:0] di_real1,
  input  logic [WIDTH-1:0] di_img1,
  output logic             do_valid,
  input  logic             do_ready,
  output logic [WIDTH-1:0] do_real,
  output logic [WIDTH-1:0] do_img,
  output logic             do_div_zero,
  output logic             do_ovf
);

  localparam int NW = 2*WIDTH+1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_reg, state_next;
  logic [CW-1:0]           cnt_reg;
  logic signed [WIDTH-1:0] r0_reg, i0_reg, r1_reg, i1_reg;
  logic [1:0]              neg_reg, ovf_reg;
  logic [WIDTH-1:0]        real_reg, img_reg;
  logic                    dz_reg, ovf_out_reg;

  logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ir, p_ri, p_r1, p_i1;
  logic [1:0][NW-1:0]        num;
  logic [NW-1:0]             den;
  logic                      den_zero;
  logic [1:0]                ovf_pre, lane_sat;
  logic [1:0][WIDTH-1:0]     lane_res;
  logic                      lane_load, lane_step;

  assign p_rr = r0_reg * r1_reg;
  assign p_ii = i0_reg * i1_reg;
  assign p_ir = i0_reg * r1_reg;
  assign p_ri = r0_reg * i1_reg;
  assign p_r1 = r1_reg * r1_reg;
  assign p_i1 = i1_reg * i1_reg;

  // Multiply by the conjugate of the denominator; den is its squared magnitude.
  assign num[0]   = {p_rr[2*WIDTH-1], p_rr} + {p_ii[2*WIDTH-1], p_ii};
  assign num[1]   = {p_ir[2*WIDTH-1], p_ir} - {p_ri[2*WIDTH-1], p_ri};
  assign den      = {1'b0, p_r1} + {1'b0, p_i1};
  assign den_zero = (den == '0);

  assign lane_load = (state_reg == PREP);
  assign lane_step = (state_reg == DIV);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [NW-1:0]    mag;
      logic [NW-1:0]    load_rem;
      logic [WIDTH-1:0] load_bits;
      logic [WIDTH-1:0] quo;

      assign mag       = num[gi][NW-1] ? -num[gi] : num[gi];
      // Dividend is mag << Q_LENGTH; its top part seeds the remainder.
      assign load_rem  = mag >> (WIDTH - Q_LENGTH);
      assign load_bits = {mag[WIDTH-Q_LENGTH-1:0], {Q_LENGTH{1'b0}}};
      assign ovf_pre[gi] = (load_rem >= den);

      div_lane_unsigned #(.RW(NW), .QW(WIDTH)) u_lane (
        .clk          (clk),
        .rst          (rst),
        .load         (lane_load),
        .step         (lane_step),
        .load_rem     (load_rem),
        .load_bits    (load_bits),
        .divisor      (den),
        .quotient_next(quo)
      );

      assign lane_sat[gi] = ovf_reg[gi] |
                            (neg_reg[gi] ? (quo > SAT_NEG) : (quo > SAT_POS));
      assign lane_res[gi] = lane_sat[gi] ? (neg_reg[gi] ? SAT_NEG : SAT_POS)
                                         : (neg_reg[gi] ? -quo : quo);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    di_ready   = 1'b0;
    do_valid   = 1'b0;
    case (state_reg)
      IDLE: begin
        di_ready = 1'b1;
        if (di_valid) state_next = PREP;
      end
      PREP: state_next = den_zero ? DONE : DIV;
      DIV:  if (cnt_reg == '0) state_next = DONE;
      DONE: begin
        do_valid = 1'b1;
        if (do_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      r0_reg      <= '0;
      i0_reg      <= '0;
      r1_reg      <= '0;
      i1_reg      <= '0;
      neg_reg     <= '0;
      ovf_reg     <= '0;
      real_reg    <= '0;
      img_reg     <= '0;
      dz_reg      <= 1'b0;
      ovf_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (di_valid) begin
          r0_reg <= di_real0;
          i0_reg <= di_img0;
          r1_reg <= di_real1;
          i1_reg <= di_img1;
        end
        PREP: begin
          neg_reg <= {num[1][NW-1], num[0][NW-1]};
          ovf_reg <= ovf_pre;
          cnt_reg <= CW'(WIDTH-1);
          if (den_zero) begin
            real_reg    <= '0;
            img_reg     <= '0;
            dz_reg      <= 1'b1;
            ovf_out_reg <= 1'b0;
          end
        end
        DIV: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            real_reg    <= lane_res[0];
            img_reg     <= lane_res[1];
            dz_reg      <= 1'b0;
            ovf_out_reg <= |lane_sat;
          end
        end
        default: ;
      endcase
    end
  end

  assign do_real     = real_reg;
  assign do_img      = img_reg;
  assign do_div_zero = dz_reg;
  assign do_ovf      = ovf_out_reg;

endmodule

// File: tb/tb_divider_complex.sv
// Directed bench for divider_complex: literal expectations per vector plus a
// wide-arithmetic model checked against every valid output cycle.
module tb_divider_complex;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         di_valid = 1'b0;
  logic         di_ready;
  logic [W-1:0] di_real0 = '0, di_img0 = '0, di_real1 = '0, di_img1 = '0;
  logic         do_valid;
  logic         do_ready = 1'b0;
  logic [W-1:0] do_real, do_img;
  logic         do_div_zero, do_ovf;

  always #5 clk = ~clk;

  divider_complex #(.WIDTH(W), .Q_LENGTH(16)) dut (
    .clk(clk), .rst(rst),
    .di_valid(di_valid), .di_ready(di_ready),
    .di_real0(di_real0), .di_img0(di_img0), .di_real1(di_real1), .di_img1(di_img1),
    .do_valid(do_valid), .do_ready(do_ready),
    .do_real(do_real), .do_img(do_img), .do_div_zero(do_div_zero), .do_ovf(do_ovf)
  );

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         dz;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact quotient of magnitudes, truncated toward zero, then sign and clamp.
  function automatic void lane_model(input logic signed [127:0] n, input logic signed [127:0] den,
                                     output logic [W-1:0] res, output logic ovf);
    logic signed [127:0] mag, q;
    mag = (n < 0) ? -n : n;
    q   = (mag <<< 16) / den;
    ovf = 1'b0;
    if (n < 0 && q > (128'sd1 <<< 31)) begin
      ovf = 1'b1; res = 32'h8000_0000;
    end else if (!(n < 0) && q > ((128'sd1 <<< 31) - 1)) begin
      ovf = 1'b1; res = 32'h7FFF_FFFF;
    end else begin
      res = (n < 0) ? 32'(-q) : 32'(q);
    end
  endfunction

  function automatic res_t model(input logic [W-1:0] r0, i0, r1, i1);
    logic signed [127:0] a, b, c, d, nr, ni, den;
    logic [W-1:0] vr, vi;
    logic o1, o2;
    res_t e;
    a = $signed(r0); b = $signed(i0); c = $signed(r1); d = $signed(i1);
    nr  = a*c + b*d;
    ni  = b*c - a*d;
    den = c*c + d*d;
    if (den == 0) begin
      e = '{re: '0, im: '0, dz: 1'b1, ovf: 1'b0};
    end else begin
      lane_model(nr, den, vr, o1);
      lane_model(ni, den, vi, o2);
      e = '{re: vr, im: vi, dz: 1'b0, ovf: o1 | o2};
    end
    return e;
  endfunction

  // Every cycle a result is presented, it must match the oldest accepted operand set.
  always @(negedge clk) begin
    if (!rst && do_valid) begin
      check("model_pending", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0)
        check("model_result", 128'({do_real, do_img, do_div_zero, do_ovf}), 128'(exp_q[0]));
      check("model_di_ready_low", 128'(di_ready), 128'd0);
    end
  end

  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else if (do_valid && do_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  task automatic run_vec(input string name, input logic [W-1:0] r0, i0, r1, i1,
                         input logic [W-1:0] e_re, e_im, input logic e_dz, e_ovf,
                         input int e_lat, input int hold);
    int   lat;
    res_t first;
    @(negedge clk);
    for (int k = 0; k < 100 && !di_ready; k++) @(negedge clk);
    check({name, "_ready"}, 128'(di_ready), 128'd1);
    di_real0 = r0; di_img0 = i0; di_real1 = r1; di_img1 = i1;
    di_valid = 1'b1; do_ready = 1'b0;
    @(posedge clk);
    exp_q.push_back(model(r0, i0, r1, i1));
    #1;
    di_valid = 1'b0;
    di_real0 = $urandom; di_img0 = $urandom; di_real1 = $urandom; di_img1 = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!do_valid && lat < 200);
    check({name, "_latency"}, 128'(lat), 128'(e_lat));
    check({name, "_real"}, 128'(do_real), 128'(e_re));
    check({name, "_img"}, 128'(do_img), 128'(e_im));
    check({name, "_div_zero"}, 128'(do_div_zero), 128'(e_dz));
    check({name, "_ovf"}, 128'(do_ovf), 128'(e_ovf));
    $display("vec %s: real=%h img=%h div_zero=%0d ovf=%0d latency=%0d",
             name, do_real, do_img, do_div_zero, do_ovf, lat);
    first = {do_real, do_img, do_div_zero, do_ovf};
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({name, "_hold"}, 128'({do_valid, di_ready, do_real, do_img, do_div_zero, do_ovf}),
            128'({1'b1, 1'b0, first}));
    end
    do_ready = 1'b1;
    @(posedge clk);
    #1 do_ready = 1'b0;
    @(negedge clk);
    check({name, "_release"}, 128'({do_valid, di_ready}), 128'b01);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 128'({di_ready, do_valid, do_real, do_img, do_div_zero, do_ovf}),
          128'({1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}));
    rst = 1'b0;

    run_vec("one_over_one", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
            32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, 34, 0);
    run_vec("one_over_j", 32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000,
            32'h0000_0000, 32'hFFFF_0000, 1'b0, 1'b0, 34, 0);
    run_vec("three4_over_1_2", 32'h0003_0000, 32'h0004_0000, 32'h0001_0000, 32'h0002_0000,
            32'h0002_3333, 32'hFFFF_999A, 1'b0, 1'b0, 34, 10);
    run_vec("div_zero", 32'h0005_0000, 32'h0005_0000, 32'h0, 32'h0,
            32'h0, 32'h0, 1'b1, 1'b0, 2, 0);
    run_vec("seven_over_seven", 32'h0007_0000, 32'h0, 32'h0007_0000, 32'h0,
            32'h0001_0000, 32'h0, 1'b0, 1'b0, 34, 0);
    run_vec("ovf_pos", 32'h7FFF_0000, 32'h0, 32'h0000_0100, 32'h0,
            32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 34, 0);
    run_vec("ovf_neg", 32'h8001_0000, 32'h0, 32'h0000_0100, 32'h0,
            32'h8000_0000, 32'h0, 1'b0, 1'b1, 34, 0);
    run_vec("neg_half", 32'hFFFE_0000, 32'h0, 32'h0004_0000, 32'h0,
            32'hFFFF_8000, 32'h0, 1'b0, 1'b0, 34, 0);
    run_vec("zero_num", 32'h0, 32'h0, 32'h0001_0000, 32'hFFFF_0000,
            32'h0, 32'h0, 1'b0, 1'b0, 34, 0);
    run_vec("max_neg_exact", 32'h8000_0000, 32'h0, 32'h0001_0000, 32'h0,
            32'h8000_0000, 32'h0, 1'b0, 1'b0, 34, 0);
    run_vec("max_pos_exact", 32'h7FFF_FFFF, 32'h0, 32'h0001_0000, 32'h0,
            32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 34, 0);

    // Abort a divide in cycle 15 with accept and release requested alongside reset.
    @(negedge clk);
    di_real0 = 32'h0003_0000; di_img0 = 32'h0004_0000;
    di_real1 = 32'h0001_0000; di_img1 = 32'h0002_0000;
    di_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(di_real0, di_img0, di_real1, di_img1));
    #1 di_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1; di_valid = 1'b1; do_ready = 1'b1;
    @(posedge clk);
    #1 di_valid = 1'b0; do_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("reset_abort_state", 128'({di_ready, do_valid, do_real, do_img, do_div_zero, do_ovf}),
          128'({1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}));
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (do_valid) seen++;
    end
    check("reset_abort_no_valid", 128'(seen), 128'd0);
    $display("vec reset_abort: valid_cycles_after_reset=%0d", seen);

    run_vec("after_reset", 32'h0007_0000, 32'h0, 32'h0007_0000, 32'h0,
            32'h0001_0000, 32'h0, 1'b0, 1'b0, 34, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
